// File: rtl/rtype_exec_seq.sv
// R-type execute sequencer: IDLE -> READ -> EXEC -> WB, one instruction per four cycles.
// Drives the regfile read ports, computes the ALU result and issues a single write-back.
module rtype_exec_seq #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [31:0]          instr,
  output logic [4:0]           readReg1,
  output logic [4:0]           readReg2,
  input  logic [DATAWIDTH-1:0] readData1,
  input  logic [DATAWIDTH-1:0] readData2,
  output logic [4:0]           writeReg,
  output logic [DATAWIDTH-1:0] writeData,
  output logic                 write,
  output logic                 done,
  output logic                 illegal
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  state_e               state_q;
  logic [5:0]           op_q;
  logic [4:0]           rd_q;
  logic [4:0]           shamt_q;
  logic [5:0]           funct_q;
  logic [DATAWIDTH-1:0] a_q;
  logic [DATAWIDTH-1:0] b_q;
  logic [DATAWIDTH-1:0] r_q;
  logic                 write_q;
  logic                 done_q;
  logic                 illegal_q;

  logic [DATAWIDTH-1:0] alu_res;
  logic                 legal;

  // ALU and legality decode on the captured operands
  always_comb begin
    alu_res = '0;
    legal   = (op_q == 6'h00);
    unique case (funct_q)
      6'h20: alu_res = a_q + b_q;
      6'h22: alu_res = a_q - b_q;
      6'h24: alu_res = a_q & b_q;
      6'h25: alu_res = a_q | b_q;
      6'h26: alu_res = a_q ^ b_q;
      6'h27: alu_res = ~(a_q | b_q);
      6'h2A: alu_res = {{(DATAWIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      6'h2B: alu_res = {{(DATAWIDTH-1){1'b0}}, (a_q < b_q)};
      6'h00: alu_res = b_q << shamt_q;
      6'h02: alu_res = b_q >> shamt_q;
      6'h03: alu_res = $signed(b_q) >>> shamt_q;
      default: legal = 1'b0;
    endcase
  end

  // Sequencer FSM with registered outputs; readReg1/2 double as the rs/rt latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
      funct_q   <= '0;
      readReg1  <= '0;
      readReg2  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      writeReg  <= '0;
      write_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            op_q     <= instr[31:26];
            readReg1 <= instr[25:21];
            readReg2 <= instr[20:16];
            rd_q     <= instr[15:11];
            shamt_q  <= instr[10:6];
            funct_q  <= instr[5:0];
            state_q  <= StRead;
          end
        end
        StRead: begin
          a_q     <= readData1;
          b_q     <= readData2;
          state_q <= StExec;
        end
        StExec: begin
          r_q       <= alu_res;
          writeReg  <= rd_q;
          done_q    <= 1'b1;
          illegal_q <= ~legal;
          write_q   <= legal && (rd_q != 5'd0);
          state_q   <= StWb;
        end
        StWb: begin
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          write_q   <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reset gates the pulses so an aborted instruction neither writes nor retires
  always_comb begin
    instr_ready = (state_q == StIdle) && !rst;
    write       = write_q && !rst;
    done        = done_q && !rst;
    illegal     = illegal_q && !rst;
    writeData   = r_q;
  end

endmodule

// File: tb/tb_rtype_exec_seq.sv
// Bench for rtype_exec_seq: behavioural regfile, directed instructions, scoreboard monitor.
module tb_rtype_exec_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  readReg1, readReg2, writeReg;
  logic [31:0] readData1, readData2, writeData;
  logic        write, done, illegal;

  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] rf [32];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = -1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wr;
    logic        ill;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  rtype_exec_seq #(.DATAWIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .readReg1   (readReg1),
    .readReg2   (readReg2),
    .readData1  (readData1),
    .readData2  (readData2),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .write      (write),
    .done       (done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Regfile model: combinational read, posedge write, bench preload port
  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (write && writeReg != 5'd0) rf[writeReg] <= writeData;
  end
  assign readData1 = rf[readReg1];
  assign readData2 = rf[readReg2];

  function automatic logic [31:0] rt(input logic [4:0] rs, input logic [4:0] rtr,
                                     input logic [4:0] rd, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {6'h00, rs, rtr, rd, sh, fn};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Present an instruction until accepted; push the expected retirement unless aborted
  task automatic issue(input logic [31:0] ins, input logic [4:0] rd, input logic [31:0] data,
                       input logic wr, input logic ill, input bit hold, input bit gap,
                       input bit push);
    exp_t e;
    int n;
    instr_valid = 1'b1;
    instr = ins;
    n = 0;
    forever begin
      @(negedge clk);
      if (instr_ready) break;
      n++;
      if (n > 20) begin
        checks++; failures++;
        $display("FAIL handshake_timeout: no instr_ready within 20 cycles");
        instr_valid = 1'b0;
        return;
      end
    end
    if (gap) chk("ready_gap", cyc - last_acc, 32'd4);
    last_acc = cyc;
    e.rd = rd; e.data = data; e.wr = wr; e.ill = ill; e.cyc = cyc + 3;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // Monitor: every retirement must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst) begin
      if (write && !done) begin
        checks++; failures++;
        $display("FAIL write_without_done: write=1 done=0 at cycle %0d", cyc);
      end
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: writeReg=%0d writeData=%h", writeReg, writeData);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (writeReg !== e.rd || write !== e.wr || illegal !== e.ill || cyc != e.cyc ||
              (!e.ill && writeData !== e.data)) begin
            failures++;
            $display("FAIL retire: got rd=%0d data=%h wr=%b ill=%b cyc=%0d expected rd=%0d data=%h wr=%b ill=%b cyc=%0d",
                     writeReg, writeData, write, illegal, cyc, e.rd, e.data, e.wr, e.ill, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 32'h0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_readReg1", readReg1, 0);
    chk("rst_writeData", writeData, 0);
    chk("rst_pulses", {write, done, illegal}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", instr_ready, 1);
    @(posedge clk); #1;

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    preload(5'd7, 32'h8000_0000);
    preload(5'd10, 32'hFFFF_FFFF);
    preload(5'd11, 32'd1);

    issue(rt(1, 2, 3, 0, 6'h20), 3, 32'd12, 1, 0, 0, 0, 1);
    issue(rt(1, 2, 4, 0, 6'h22), 4, 32'hFFFF_FFFE, 1, 0, 0, 0, 1);
    issue(rt(1, 2, 5, 0, 6'h2A), 5, 32'd1, 1, 0, 0, 0, 1);
    issue(rt(10, 11, 12, 0, 6'h2B), 12, 32'd0, 1, 0, 0, 0, 1);
    issue(rt(10, 11, 13, 0, 6'h2A), 13, 32'd1, 1, 0, 0, 0, 1);
    issue(rt(0, 7, 6, 4, 6'h03), 6, 32'hF800_0000, 1, 0, 0, 0, 1);
    issue(rt(0, 7, 6, 4, 6'h02), 6, 32'h0800_0000, 1, 0, 0, 0, 1);
    issue(rt(0, 7, 6, 1, 6'h00), 6, 32'h0000_0000, 1, 0, 0, 0, 1);
    issue(rt(1, 2, 14, 0, 6'h24), 14, 32'd5, 1, 0, 0, 0, 1);
    issue(rt(1, 2, 15, 0, 6'h25), 15, 32'd7, 1, 0, 0, 0, 1);
    issue(rt(1, 2, 16, 0, 6'h26), 16, 32'd2, 1, 0, 0, 0, 1);
    issue(rt(1, 2, 17, 0, 6'h27), 17, 32'hFFFF_FFF8, 1, 0, 0, 0, 1);
    issue(rt(1, 1, 18, 0, 6'h20), 18, 32'd10, 1, 0, 0, 0, 1);
    issue(rt(1, 2, 0, 0, 6'h20), 0, 32'd12, 0, 0, 0, 0, 1);
    issue({6'h23, 5'd1, 5'd2, 5'd19, 5'd0, 6'h20}, 19, 32'd0, 0, 1, 0, 0, 1);
    issue(rt(1, 2, 20, 0, 6'h3F), 20, 32'd0, 0, 1, 0, 0, 1);
    drain();
    chk("rf_r3", rf[3], 32'd12);
    chk("rf_r6", rf[6], 32'd0);

    // Back-to-back with valid held; third depends on first's destination
    preload(5'd3, 32'd0);
    issue(rt(1, 2, 3, 0, 6'h20), 3, 32'd12, 1, 0, 1, 0, 1);
    issue(rt(1, 2, 21, 0, 6'h25), 21, 32'd7, 1, 0, 1, 1, 1);
    issue(rt(3, 1, 22, 0, 6'h20), 22, 32'd17, 1, 0, 0, 1, 1);
    drain();
    chk("rf_r22", rf[22], 32'd17);

    // rd equals rs/rt: old value is used
    issue(rt(2, 2, 2, 0, 6'h20), 2, 32'd14, 1, 0, 0, 0, 1);
    drain();
    chk("rf_r2", rf[2], 32'd14);

    // Reset during WB aborts silently
    preload(5'd3, 32'h0000_DEAD);
    issue(rt(1, 2, 3, 0, 6'h20), 3, 32'd19, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wb_write", write, 0);
    chk("rst_wb_done", done, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_hold_ready", instr_ready, 0);
    chk("rst_clear_data", writeData, 0);
    chk("rst_clear_reg1", readReg1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", instr_ready, 1);
    chk("rf_r3_kept", rf[3], 32'h0000_DEAD);
    chk("sb_empty_end", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
